mmio_pwm: RTL and testbench
===========================

MMIO_PWM -- requirements
Module: mmio_pwm

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_2000, word-aligned base of the 32-byte register window.
REQ-002 Parameter CNT_W, default 16, width of the period counter and the duty/period registers.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 dmem_wren  input  1  write strobe from the core's data-memory bus.
REQ-006 dmem_address  input  32  byte address from the core.
REQ-007 dmem_data_in  input  32  write data.
REQ-008 funct3  input  3  access size; only 3'b010 (word) writes are accepted.
REQ-009 dmem_data_out  output  32  registered read data.
REQ-010 led, red, green, blue  output  1 each  active-high PWM outputs; the top level inverts them for the pads.

Function
REQ-011 Register map, offsets from BASE_ADDR: 0x00 CTRL (bit0 enable, bit1 fade), 0x04 PERIOD, 0x08 DUTY_R, 0x0C DUTY_G, 0x10 DUTY_B, 0x14 DUTY_L, 0x18 COUNT (read-only), 0x1C FADE_STEP[7:0].
REQ-012 A write takes effect on the clock edge where dmem_wren=1, funct3=3'b010, and the address decodes to the window; any other combination is ignored.
REQ-013 Write data above CNT_W bits is discarded; writes to COUNT are ignored.
REQ-014 dmem_data_out presents the addressed register, zero-extended, one cycle after the address is presented.
REQ-015 dmem_data_out is 0 for out-of-window or unmapped addresses; bits [1:0] of the address are ignored.
REQ-016 PERIOD and DUTY_x writes land in shadow registers and are readable immediately; they do not affect the outputs until copied.
REQ-017 Shadow values are copied into the active registers on the wrap cycle (count==active PERIOD) and, when enable rises, on the first enabled cycle.
REQ-018 A shadow write in the wrap cycle is not copied by that wrap; it takes effect at the following wrap.
REQ-019 While enable=1, count increments each cycle from 0 to active PERIOD and then wraps to 0.
REQ-020 With PERIOD=0, count stays at 0 and the wrap occurs every cycle.
REQ-021 While enable=1, each output is high iff count < its active duty; duty=0 gives always-low and duty > PERIOD gives always-high (100%).
REQ-022 While enable=0, count is held at 0 and all outputs are 0 on the cycle after enable is cleared.
REQ-023 Outputs are registered and glitch-free; the output period is PERIOD+1 cycles.

Reset
REQ-024 On reset: CTRL=0, PERIOD=shadow PERIOD=active PERIOD=16'h00FF.
REQ-025 On reset: all duties (shadow and active)=0, FADE_STEP=0, count=0.
REQ-026 On reset: led/red/green/blue=0 and dmem_data_out=0.
REQ-027 Reset asserted mid-period wins over any simultaneous write and takes effect on that edge.

Configuration
REQ-028 The macro PWM_FADE_EN, when defined, enables hardware breathing on the led channel.
REQ-029 With PWM_FADE_EN and CTRL.fade=1, the active DUTY_L changes by FADE_STEP at each wrap, forming a triangle wave.
REQ-030 The fade ramps up, saturating at PERIOD+1 before reversing, then ramps down, saturating at 0 before reversing; the ramp direction resets to up.
REQ-031 With PWM_FADE_EN and CTRL.fade=1, shadow DUTY_L is not copied.
REQ-032 Without PWM_FADE_EN, CTRL bit1 and FADE_STEP read 0, their writes are ignored, and no fade logic is synthesised.

Verification
REQ-033 Reset, PERIOD=3, DUTY_R=2, enable -> red pattern 1,1,0,0 repeating; COUNT reads cycle 0..3.
REQ-034 Mid-period, write DUTY_G=1 with count=1 -> green is unchanged until the next wrap, then high for 1 of every 4 cycles.
REQ-035 DUTY_B=0 gives blue always 0; DUTY_B=16'hFFFF with PERIOD=3 gives blue always 1; PERIOD=0 with DUTY_R=1 gives red constant 1.
REQ-036 A write with funct3=3'b000 to 0x2008, or a write to 0x2020, leaves the registers unchanged; a read of 0x2020 returns 0.
REQ-037 Clearing enable mid-period -> outputs 0 and COUNT=0 next cycle; asserting reset during a write to 0x2004 -> PERIOD reads 0x00FF.
REQ-038 With PWM_FADE_EN: PERIOD=7, FADE_STEP=4, fade=1, enable -> active DUTY_L goes 0,4,8,4,0,4 on successive wraps.

Source files
------------

// File: rtl/mmio_pwm.sv
// Memory-mapped four-channel PWM (red/green/blue/led) with shadowed period and duty registers.
// Define PWM_FADE_EN to add hardware breathing (triangle-wave duty) on the led channel.
module mmio_pwm #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int          CNT_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_wren,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  input  logic [2:0]  funct3,
  output logic [31:0] dmem_data_out,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  typedef enum logic [2:0] {
    REG_CTRL, REG_PERIOD, REG_DUTY_R, REG_DUTY_G,
    REG_DUTY_B, REG_DUTY_L, REG_COUNT, REG_FADE
  } reg_e;

  // Channel index: 0 red, 1 green, 2 blue, 3 led.
  localparam int N_CH = 4;

  logic             hit, wr;
  reg_e             sel;
  logic [CNT_W-1:0] wdata;

  logic             ctrl_en, en_nxt;
  logic [CNT_W-1:0] period_sh, period_act, period_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] duty_sh  [N_CH];
  // One extra bit so a fading led duty can reach PERIOD+1 without wrapping.
  logic [CNT_W:0]   duty_act [N_CH];
  logic [CNT_W:0]   duty_nxt [N_CH];
  logic [N_CH-1:0]  out_nxt;
  logic             rise, wrap, load;
  logic [31:0]      rdata;
  logic             unused_bits;

`ifdef PWM_FADE_EN
  logic             ctrl_fade, fade_nxt;
  logic [7:0]       fade_step;
  logic             fade_down, fade_down_nxt;
  logic [CNT_W:0]   fade_top, fade_sum;
`endif

  assign hit         = (dmem_address[31:5] == BASE_ADDR[31:5]);
  assign sel         = reg_e'(dmem_address[4:2]);
  assign wr          = dmem_wren && (funct3 == 3'b010) && hit;
  assign wdata       = dmem_data_in[CNT_W-1:0];
  assign unused_bits = ^{dmem_address[1:0], dmem_data_in[31:CNT_W]};

  // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    en_nxt = ctrl_en;
    if (wr && sel == REG_CTRL) en_nxt = dmem_data_in[0];
    rise       = en_nxt && !ctrl_en;
    wrap       = ctrl_en && (count == period_act);
    load       = rise || wrap;
    period_nxt = load ? period_sh : period_act;
    count_nxt  = (!en_nxt || load) ? '0 : count + 1'b1;
    for (int i = 0; i < N_CH; i++) duty_nxt[i] = load ? {1'b0, duty_sh[i]} : duty_act[i];

`ifdef PWM_FADE_EN
    fade_nxt = ctrl_fade;
    if (wr && sel == REG_CTRL) fade_nxt = dmem_data_in[1];
    fade_down_nxt = fade_down;
    fade_top      = {1'b0, period_nxt} + 1'b1;
    fade_sum      = duty_act[3] + (CNT_W+1)'(fade_step);
    if (fade_nxt) begin
      // The breathing ramp owns the led duty; its shadow is never copied.
      duty_nxt[3] = duty_act[3];
      if (wrap) begin
        if (!fade_down) begin
          if (fade_sum >= fade_top) begin
            duty_nxt[3]   = fade_top;
            fade_down_nxt = 1'b1;
          end else begin
            duty_nxt[3] = fade_sum;
          end
        end else if (duty_act[3] <= (CNT_W+1)'(fade_step)) begin
          duty_nxt[3]   = '0;
          fade_down_nxt = 1'b0;
        end else begin
          duty_nxt[3] = duty_act[3] - (CNT_W+1)'(fade_step);
        end
      end
    end
`endif

    // Outputs are computed from next-state values so the registered pins line up with count.
    for (int i = 0; i < N_CH; i++) out_nxt[i] = en_nxt && ({1'b0, count_nxt} < duty_nxt[i]);

    rdata = '0;
    if (hit) begin
      case (sel)
`ifdef PWM_FADE_EN
        REG_CTRL:   rdata = {30'b0, ctrl_fade, ctrl_en};
        REG_FADE:   rdata = {24'b0, fade_step};
`else
        REG_CTRL:   rdata = {31'b0, ctrl_en};
`endif
        REG_PERIOD: rdata = 32'(period_sh);
        REG_DUTY_R: rdata = 32'(duty_sh[0]);
        REG_DUTY_G: rdata = 32'(duty_sh[1]);
        REG_DUTY_B: rdata = 32'(duty_sh[2]);
        REG_DUTY_L: rdata = 32'(duty_sh[3]);
        REG_COUNT:  rdata = 32'(count);
        default:    rdata = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en       <= 1'b0;
      period_sh     <= CNT_W'(8'hFF);
      period_act    <= CNT_W'(8'hFF);
      count         <= '0;
      for (int i = 0; i < N_CH; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
      {led, red, green, blue} <= '0;
      dmem_data_out <= '0;
`ifdef PWM_FADE_EN
      ctrl_fade     <= 1'b0;
      fade_step     <= '0;
      fade_down     <= 1'b0;
`endif
    end else begin
      ctrl_en       <= en_nxt;
      period_act    <= period_nxt;
      count         <= count_nxt;
      for (int i = 0; i < N_CH; i++) duty_act[i] <= duty_nxt[i];
      red           <= out_nxt[0];
      green         <= out_nxt[1];
      blue          <= out_nxt[2];
      led           <= out_nxt[3];
      dmem_data_out <= rdata;
`ifdef PWM_FADE_EN
      ctrl_fade     <= fade_nxt;
      fade_down     <= fade_down_nxt;
`endif
      if (wr) begin
        case (sel)
          REG_PERIOD: period_sh  <= wdata;
          REG_DUTY_R: duty_sh[0] <= wdata;
          REG_DUTY_G: duty_sh[1] <= wdata;
          REG_DUTY_B: duty_sh[2] <= wdata;
          REG_DUTY_L: duty_sh[3] <= wdata;
`ifdef PWM_FADE_EN
          REG_FADE:   fade_step  <= dmem_data_in[7:0];
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mmio_pwm.sv
// Self-checking bench for mmio_pwm: directed register/boundary steps plus randomized PWM
// patterns checked against per-cycle expectations derived from period/duty arithmetic.
module tb_mmio_pwm;

  localparam logic [31:0] A_CTRL   = 32'h2000;
  localparam logic [31:0] A_PERIOD = 32'h2004;
  localparam logic [31:0] A_DUTY_R = 32'h2008;
  localparam logic [31:0] A_DUTY_G = 32'h200C;
  localparam logic [31:0] A_DUTY_B = 32'h2010;
  localparam logic [31:0] A_DUTY_L = 32'h2014;
  localparam logic [31:0] A_COUNT  = 32'h2018;
  localparam logic [31:0] A_FADE   = 32'h201C;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmem_wren;
  logic [31:0] dmem_address;
  logic [31:0] dmem_data_in;
  logic [2:0]  funct3;
  logic [31:0] dmem_data_out;
  logic        led, red, green, blue;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] shadow_r;

  mmio_pwm dut (
    .clk(clk), .reset(reset), .dmem_wren(dmem_wren), .dmem_address(dmem_address),
    .dmem_data_in(dmem_data_in), .funct3(funct3), .dmem_data_out(dmem_data_out),
    .led(led), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f = 3'b010);
    dmem_wren    = 1'b1;
    dmem_address = a;
    dmem_data_in = d;
    funct3       = f;
    tick();
    dmem_wren    = 1'b0;
    funct3       = 3'b010;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    dmem_wren    = 1'b0;
    dmem_address = a;
    tick();
    d = dmem_data_out;
  endtask

  function automatic logic [31:0] pins();
    return {28'b0, led, red, green, blue};
  endfunction

  // Expected pin vector {led,red,green,blue} for a given position inside the period.
  function automatic logic [31:0] exp_pins(input int pos, input int dr, input int dg,
                                           input int db, input int dl);
    return {28'b0, pos < dl, pos < dr, pos < dg, pos < db};
  endfunction

  function automatic int rand_duty(input int p);
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return int'($urandom_range(0, p + 1));
      2:       return p + 1 + int'($urandom_range(0, 3));
      default: return 16'hFFFF;
    endcase
  endfunction

  // Program a pattern, enable, and check pins and COUNT readback for ncyc cycles, then disable.
  task automatic run_pattern(input int p, input int dr, input int dg, input int db,
                             input int dl, input int ncyc);
    logic [31:0] v;
    wr(A_CTRL, 0);
    check("disabled_pins", pins(), 0);
    wr(A_PERIOD, p);
    wr(A_DUTY_R, dr);
    wr(A_DUTY_G, dg);
    wr(A_DUTY_B, db);
    wr(A_DUTY_L, dl);
    shadow_r = dr;
    rd(A_DUTY_R, v);
    check("duty_r_shadow", v, dr);
    wr(A_CTRL, 1);
    dmem_address = A_COUNT;
    for (int k = 0; k < ncyc; k++) begin
      check($sformatf("pins p=%0d k=%0d", p, k), pins(), exp_pins(k % (p + 1), dr, dg, db, dl));
      if (k >= 1) check($sformatf("count p=%0d k=%0d", p, k), dmem_data_out, (k - 1) % (p + 1));
      tick();
    end
    wr(A_CTRL, 0);
    check("off_pins", pins(), 0);
    rd(A_COUNT, v);
    check("off_count", v, 0);
  endtask

  initial begin
    logic [31:0] v;
    reset        = 1'b1;
    dmem_wren    = 1'b0;
    dmem_address = '0;
    dmem_data_in = '0;
    funct3       = 3'b010;
    tick();
    tick();
    check("reset_pins", pins(), 0);
    check("reset_rdata", dmem_data_out, 0);
    reset = 1'b0;

    rd(A_CTRL, v);   check("rst_ctrl", v, 0);
    rd(A_PERIOD, v); check("rst_period", v, 32'hFF);
    rd(A_DUTY_R, v); check("rst_duty_r", v, 0);
    rd(A_DUTY_L, v); check("rst_duty_l", v, 0);
    rd(A_COUNT, v);  check("rst_count", v, 0);
    rd(A_FADE, v);   check("rst_fade", v, 0);

    // Canonical pattern: red 1,1,0,0; green 25%; blue 0%; led 100%.
    run_pattern(3, 2, 1, 0, 16'hFFFF, 9);
    // PERIOD=0: count pinned at 0, red constant high.
    run_pattern(0, 1, 0, 0, 0, 4);

    for (int it = 0; it < 6; it++) begin
      int p;
      p = int'($urandom_range(0, 6));
      run_pattern(p, rand_duty(p), rand_duty(p), rand_duty(p), rand_duty(p), 2 * (p + 1) + 1);
    end

    // Mid-period duty update lands at the next wrap; a write in the wrap cycle waits one more.
    wr(A_CTRL, 0);
    wr(A_PERIOD, 3);
    wr(A_DUTY_R, 0);
    wr(A_DUTY_G, 0);
    wr(A_DUTY_B, 0);
    wr(A_DUTY_L, 0);
    shadow_r = 0;
    wr(A_CTRL, 1);
    tick();
    wr(A_DUTY_G, 1);
    dmem_address = A_DUTY_G;
    check("g_hold k2", {31'b0, green}, 0);
    tick();
    check("g_shadow_read", dmem_data_out, 1);
    check("g_hold k3", {31'b0, green}, 0);
    wr(A_DUTY_B, 4);
    for (int k = 4; k < 12; k++) begin
      check($sformatf("g_new k=%0d", k), {31'b0, green}, (k % 4) < 1);
      check($sformatf("b_wrapwrite k=%0d", k), {31'b0, blue}, k >= 8);
      tick();
    end
    wr(A_CTRL, 0);
    check("off_pins2", pins(), 0);

    // Ignored accesses, truncation, byte-offset aliasing.
    wr(A_DUTY_R, 5, 3'b000);
    wr(32'h2020, 1);
    wr(A_COUNT, 7);
    rd(A_DUTY_R, v);     check("bad_funct3", v, shadow_r);
    rd(A_CTRL, v);       check("oow_write", v, 0);
    rd(32'h2020, v);     check("oow_read", v, 0);
    rd(A_COUNT, v);      check("count_ro", v, 0);
    wr(A_PERIOD, 32'hABCD_0009);
    rd(32'h2006, v);     check("period_trunc", v, 9);

    // Reset beats a simultaneous write.
    dmem_wren    = 1'b1;
    dmem_address = A_PERIOD;
    dmem_data_in = 32'h33;
    reset        = 1'b1;
    tick();
    reset     = 1'b0;
    dmem_wren = 1'b0;
    check("rst_write_pins", pins(), 0);
    check("rst_write_rdata", dmem_data_out, 0);
    rd(A_PERIOD, v); check("rst_write_period", v, 32'hFF);

`ifdef PWM_FADE_EN
    begin
      int exp_d [6] = '{0, 4, 8, 4, 0, 4};
      wr(A_PERIOD, 7);
      wr(A_FADE, 4);
      rd(A_FADE, v); check("fade_step_read", v, 4);
      wr(A_CTRL, 3);
      for (int k = 0; k < 48; k++) begin
        check($sformatf("fade_led k=%0d", k), {31'b0, led}, (k % 8) < exp_d[k / 8]);
        tick();
      end
      wr(A_CTRL, 0);
    end
`else
    wr(A_FADE, 4);
    rd(A_FADE, v); check("fade_step_absent", v, 0);
    wr(A_CTRL, 3);
    rd(A_CTRL, v); check("fade_bit_absent", v, 1);
    wr(A_CTRL, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
